// File: rtl/parking_lane_controller.sv
// parking_lane_controller: filters lane photo-sensors, tracks vehicles per lane, drives gates and occupancy pulses
module parking_lane_fsm #(
    parameter int TIMEOUT  = 1000,
    parameter bit DENY_ERR = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    input  logic admit,
    output logic gate,
    output logic done,
    output logic err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, SEEN_A, SEEN_AB, SEEN_B, DENY, WRONG} state_t;
    state_t state;
    logic [TW-1:0] timer;
    logic transit;
    logic expired;
    assign transit = state inside {SEEN_A, SEEN_AB, SEEN_B};
    assign expired = transit && timer == TW'(TIMEOUT - 1);
    // lane sequencing; gate lags the state by one cycle, done/err are single-cycle pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            timer <= '0;
            gate  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            gate  <= transit;
            done  <= 1'b0;
            err   <= 1'b0;
            timer <= transit ? timer + 1'b1 : '0;
            if (expired) begin
                state <= WRONG;
                err   <= 1'b1;
            end else begin
                case (state)
                    IDLE: case ({a, b})
                        2'b10: begin
                            state <= admit ? SEEN_A : DENY;
                            err   <= DENY_ERR && !admit;
                        end
                        2'b00: state <= IDLE;
                        default: begin
                            state <= WRONG;
                            err   <= 1'b1;
                        end
                    endcase
                    SEEN_A: case ({a, b})
                        2'b11: state <= SEEN_AB;
                        2'b00: state <= IDLE;
                        2'b01: begin
                            state <= WRONG;
                            err   <= 1'b1;
                        end
                        default: ;
                    endcase
                    SEEN_AB: case ({a, b})
                        2'b01: state <= SEEN_B;
                        2'b10: state <= SEEN_A;
                        2'b00: begin
                            state <= WRONG;
                            err   <= 1'b1;
                        end
                        default: ;
                    endcase
                    SEEN_B: case ({a, b})
                        2'b00: begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                        2'b11: state <= SEEN_AB;
                        2'b10: begin
                            state <= WRONG;
                            err   <= 1'b1;
                        end
                        default: ;
                    endcase
                    DENY, WRONG: state <= ({a, b} == 2'b00) ? IDLE : state;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

module parking_lane_controller #(
    parameter int CAPACITY   = 99,
    parameter int CW         = 7,
    parameter int DEB_CYCLES = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en_a,
    input  logic          en_b,
    input  logic          ex_a,
    input  logic          ex_b,
    input  logic [CW-1:0] count,
    output logic          inc,
    output logic          dec,
    output logic          entry_gate,
    output logic          exit_gate,
    output logic          full,
    output logic          empty,
    output logic          entry_err,
    output logic          exit_err
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic [3:0] raw, sync1, sync2, filt;
    logic en_done, ex_done, en_fsm_err, ex_fsm_err, en_arb_err, ex_arb_err;
    assign raw   = {en_a, en_b, ex_a, ex_b};
    assign full  = count >= CW'(CAPACITY);
    assign empty = count == '0;
    assign entry_err = en_fsm_err | en_arb_err;
    assign exit_err  = ex_fsm_err | ex_arb_err;
    // two-stage synchroniser for the asynchronous sensor inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end
    for (genvar i = 0; i < 4; i++) begin : g_deb
        logic [DW-1:0] run;
        logic f;
        // adopt a new level only after DEB_CYCLES consecutive disagreeing samples
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                run <= '0;
                f   <= 1'b0;
            end else if (sync2[i] == f) begin
                run <= '0;
            end else if (run == DW'(DEB_CYCLES - 1)) begin
                run <= '0;
                f   <= sync2[i];
            end else begin
                run <= run + 1'b1;
            end
        end
        assign filt[i] = f;
    end
    parking_lane_fsm #(.TIMEOUT(TIMEOUT), .DENY_ERR(1'b0)) u_entry (
        .clk(clk), .reset(reset), .a(filt[3]), .b(filt[2]), .admit(!full),
        .gate(entry_gate), .done(en_done), .err(en_fsm_err)
    );
    parking_lane_fsm #(.TIMEOUT(TIMEOUT), .DENY_ERR(1'b1)) u_exit (
        .clk(clk), .reset(reset), .a(filt[1]), .b(filt[0]), .admit(!empty),
        .gate(exit_gate), .done(ex_done), .err(ex_fsm_err)
    );
    // simultaneous completions cancel; otherwise bump the counter unless it is already at its limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc        <= 1'b0;
            dec        <= 1'b0;
            en_arb_err <= 1'b0;
            ex_arb_err <= 1'b0;
        end else begin
            inc        <= en_done && !ex_done && !full;
            en_arb_err <= en_done && !ex_done && full;
            dec        <= ex_done && !en_done && !empty;
            ex_arb_err <= ex_done && !en_done && empty;
        end
    end
endmodule

// File: doc/parking_lane_controller.md
Name: parking_lane_controller

Overview:
Sequences the occupancy counter from entry and exit lane photo-sensor pairs. Each lane has an outer sensor (a) and inner sensor (b).
- Filters each sensor, tracks each vehicle through the a→ab→b→none pattern, and drives the gate.
- Issues single-cycle inc/dec pulses to the occupancy counter.
- Arbitrates simultaneous entry and exit completions and refuses entry when the lot is full.

Parameters:
CAPACITY, 99, max occupancy; matches counter saturation
CW, 7, count width
DEB_CYCLES, 4, consecutive stable cycles required before a filtered sensor changes
TIMEOUT, 1000, max cycles a lane may sit mid-transit before abort

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
en_a  in  1  entry outer sensor, raw, asynchronous
en_b  in  1  entry inner sensor, raw, asynchronous
ex_a  in  1  exit inner-lot sensor, raw, asynchronous
ex_b  in  1  exit street-side sensor, raw, asynchronous
count  in  CW  current occupancy from counter
inc  out  1  one-cycle increment pulse to counter
dec  out  1  one-cycle decrement pulse to counter
entry_gate  out  1  entry barrier open
exit_gate  out  1  exit barrier open
full  out  1  count >= CAPACITY (combinational)
empty  out  1  count == 0 (combinational)
entry_err  out  1  one-cycle pulse on entry-lane anomaly
exit_err  out  1  one-cycle pulse on exit-lane anomaly

Behaviour:
- Reset (reset=0, async): synchronisers, filters, timers cleared; both lane FSMs IDLE; inc, dec, gates, err = 0. Reset mid-transit discards that vehicle; no inc/dec is issued.
- Input path: each raw sensor passes a 2-FF synchroniser, then a debounce filter.
  - Filtered value takes the synchronised value after DEB_CYCLES consecutive equal samples.
  - Raw→filtered latency is 2+DEB_CYCLES cycles.
  - Glitches shorter than DEB_CYCLES are ignored.
- Lane FSM: identical per lane, on filtered (a,b). States: IDLE, A, AB, B, DENY, WRONG.
  - IDLE: (1,0) → A if admitted, else DENY. (0,1) or (1,1) → WRONG, pulse err. (0,0) stays.
  - A: (1,1) → AB; (0,0) → IDLE (backed out, no event).
  - AB: (0,1) → B; (1,0) → A.
  - B: (0,0) → IDLE and raise done; (1,1) → AB.
  - Any two-bit jump not listed above (A↔B direct, A(0,1), B(1,0)) → WRONG, pulse err.
  - DENY and WRONG: hold until (0,0), then IDLE. No event is generated.
  - Timeout: a counter runs while in A, AB or B and clears on leaving them. On reaching TIMEOUT: → WRONG, pulse err.
- Admission, evaluated on the IDLE→A edge:
  - Entry lane admitted iff !full.
  - Exit lane admitted iff !empty; otherwise → DENY and pulse exit_err.
- Gates: entry_gate=1 in entry A/AB/B; exit_gate=1 in exit A/AB/B. Registered outputs, asserted the cycle after the state is entered. Gates stay 0 in DENY and WRONG.
- Arbitration, registered (inc/dec one cycle after done):
  - Entry done only: inc=1, provided count < CAPACITY at that cycle; otherwise suppressed and entry_err pulses.
  - Exit done only: dec=1, provided count > 0; otherwise suppressed and exit_err pulses.
  - Both done in the same cycle: net zero, so inc=dec=0 and no err.
  - inc and dec are never high together. Each is at most 1 cycle wide per vehicle.
- A new vehicle cannot start on a lane until its FSM returns to IDLE, which requires (0,0).

Test Plan:
- Reset release, count=0, entry sequence (1,0)→(1,1)→(0,1)→(0,0), each held 10 cycles → entry_gate high during transit, single inc pulse one cycle after return to IDLE, full=0.
- count=99, entry (1,0) → DENY: entry_gate stays 0, no inc, no err. Clear to (0,0) → IDLE.
- Entry and exit sequences aligned so both reach done in the same cycle, count=50 → no inc, no dec, no err.
- Entry (1,0)→(0,0) backout; then 2-cycle glitch on en_b with DEB_CYCLES=4 → no inc, no err, FSM stays IDLE.
- Exit lane raw (0,1) first (wrong way) → exit_err 1-cycle pulse, WRONG until (0,0). Separately, hold (1,1) beyond TIMEOUT → exit_err pulse, exit_gate drops.
- Assert reset=0 asynchronously while entry FSM is in AB → all outputs 0 immediately. After release with sensors (0,0) → IDLE, no inc issued.
